dlsc_stereobm_pipe_best: RTL and testbench
==========================================

Name: dlsc_stereobm_pipe_best

Overview:
- Consumes the per-disparity SAD sums produced by the stereo block-matching adder stage, MULT_R rows in parallel.
- For each pixel it sweeps a run of disparity beats (first…last) and tracks, per row, the minimum SAD, its disparity and the second-lowest SAD.
- At the end of the run it emits the winning disparity and SAD per row, plus a uniqueness-filter flag.
- Feeds the disparity output formatter.

Parameters:
- SUM_BITS, 20, width of one SAD sum.
- MULT_R, 3, rows processed in parallel.
- DISP_BITS, 6, width of a disparity index.
- UNIQ_MUL, 4, uniqueness margin in 1/16 units of best SAD; 0 disables the filter.
- SUM_BITS_R, SUM_BITS*MULT_R, derived; don't touch.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid (no backpressure)
- in_first  in  1  first disparity of a pixel run; qualified by in_valid
- in_last  in  1  last disparity of a pixel run; qualified by in_valid
- in_disp  in  DISP_BITS  disparity index of this beat
- in_data  in  SUM_BITS_R  SADs, row j at [j*SUM_BITS +: SUM_BITS]
- out_valid  out  1  result valid, one-cycle pulse per run
- out_disp  out  DISP_BITS*MULT_R  best disparity per row
- out_sad  out  SUM_BITS_R  best SAD per row
- out_filtered  out  MULT_R  1 = row j failed the uniqueness test

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - out_valid=0, out_disp=0, out_sad=0, out_filtered=0.
  - Internal state goes to IDLE; per-row best/second registers go to all-ones.
- State machine:
  - IDLE -> ACTIVE on in_valid & in_first & !in_last.
  - IDLE with in_valid & in_first & in_last: single-beat run; emit next cycle and stay IDLE.
  - ACTIVE -> IDLE on in_valid & in_last.
- Per-row update on each accepted beat, SAD s:
  - in_first: best=s, bdisp=in_disp, second=all-ones. Prior accumulation is discarded.
  - otherwise, if s < best (strict): second=best, best=s, bdisp=in_disp.
  - else if s < second: second=s.
  - Ties keep the earlier disparity.
- Beats arriving in IDLE without in_first are ignored entirely, with no state change.
- in_first while ACTIVE restarts the run from that beat; no output for the aborted run.
- Gaps (in_valid=0) inside a run are allowed; state is held.
- Output timing:
  - out_valid asserts exactly 1 cycle after the in_last beat.
  - out_disp, out_sad and out_filtered are registered together with out_valid and hold their values until the next result.
  - The in_last beat is itself included in the min computation.
  - Back-to-back runs (in_last followed immediately by in_first) are supported at full rate.
- Uniqueness test, per row:
  - margin = (best*UNIQ_MUL)>>4, computed in SUM_BITS+5 bits with no truncation.
  - filtered = (best + margin >= second).
  - With UNIQ_MUL=0, filtered=0 always.
  - second is all-ones for a single-beat run, so such a run is unfiltered unless best+margin >= 2^SUM_BITS-1.
- in_disp is taken verbatim: no check that it increments or is monotonic.
- A mid-run reset drops the run; no out_valid is produced for it.

Test Plan:
- MULT_R=3, UNIQ_MUL=4. Run disp 0..3 with row0 SADs 100,50,80,90 -> 1 cycle after last: out_disp[row0]=1, out_sad=50; second=80, 50+12=62<80 -> filtered=0.
- Row1 SADs 60,40,42,70 -> best 40 at disp 1, second 42, 40+10>=42 -> filtered[1]=1. Repeat with UNIQ_MUL=0 -> filtered[1]=0.
- Tie: row2 SADs 30,30,30 -> out_disp=0 (earliest), filtered=1. Single-beat run with first&last, SAD 7 at disp 5 -> out_disp=5, out_sad=7, filtered=0, out_valid one cycle later.
- Run A last beat followed immediately by run B first beat, with invalid gaps inside B -> two out_valid pulses; B's result is unaffected by A's values or by the gaps.
- in_first mid-run (after 2 beats) -> the aborted run produces no output; the result reflects only beats from the restart. Stray beats in IDLE without first -> no output.
- Assert rst during a run -> all outputs 0 the next cycle. A subsequent complete run of 4 beats -> exactly one out_valid with correct values.

Source files
------------

// File: rtl/dlsc_stereobm_pipe_best_if.sv
// Bundle of the beat input and result output of the stereo BM best-disparity stage.
//   in_valid/in_first/in_last : beat qualifiers (no backpressure)
//   in_disp                   : disparity index of the beat
//   in_data                   : MULT_R SAD sums, row j at [j*SUM_BITS +: SUM_BITS]
//   out_valid                 : one-cycle result pulse per completed run
//   out_disp/out_sad          : winning disparity / SAD per row
//   out_filtered              : per-row uniqueness failure flag
// master = producer of beats / consumer of results, slave = the best-select stage.
interface dlsc_stereobm_pipe_best_if #(
  parameter int SUM_BITS  = 20,
  parameter int MULT_R    = 3,
  parameter int DISP_BITS = 6
);
  localparam int SUM_BITS_R = SUM_BITS * MULT_R;

  logic                          in_valid;
  logic                          in_first;
  logic                          in_last;
  logic [DISP_BITS-1:0]          in_disp;
  logic [SUM_BITS_R-1:0]         in_data;
  logic                          out_valid;
  logic [DISP_BITS*MULT_R-1:0]   out_disp;
  logic [SUM_BITS_R-1:0]         out_sad;
  logic [MULT_R-1:0]             out_filtered;

  modport master (
    output in_valid, in_first, in_last, in_disp, in_data,
    input  out_valid, out_disp, out_sad, out_filtered
  );

  modport slave (
    input  in_valid, in_first, in_last, in_disp, in_data,
    output out_valid, out_disp, out_sad, out_filtered
  );
endinterface

// File: rtl/dlsc_stereobm_pipe_best.sv
// Best-disparity selection for stereo block matching.
// Sweeps a run of disparity beats (first..last) and tracks per row the minimum
// SAD, its disparity and the second-lowest SAD. One cycle after the last beat it
// emits the winner per row plus a uniqueness flag (best + best*UNIQ_MUL/16 >= second).
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : slave side of dlsc_stereobm_pipe_best_if (beats in, results out)
module dlsc_stereobm_pipe_best #(
  parameter int SUM_BITS   = 20,
  parameter int MULT_R     = 3,
  parameter int DISP_BITS  = 6,
  parameter int UNIQ_MUL   = 4,
  parameter int SUM_BITS_R = SUM_BITS * MULT_R
) (
  input  logic                        clk,
  input  logic                        rst,
  dlsc_stereobm_pipe_best_if.slave    bus
);

  // Extended width for the uniqueness arithmetic so best*UNIQ_MUL never wraps.
  localparam int EXT_BITS = SUM_BITS + 5;
  localparam logic [EXT_BITS-1:0] UNIQ_EXT = EXT_BITS'(UNIQ_MUL);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                        r_state;
  logic                          r_out_valid;
  logic [DISP_BITS*MULT_R-1:0]   r_out_disp;
  logic [SUM_BITS_R-1:0]         r_out_sad;
  logic [MULT_R-1:0]             r_out_filtered;

  // A beat counts if it starts a run (any state) or continues one in ACTIVE.
  // Beats in IDLE without in_first are dropped.
  logic w_accept;
  logic w_end;
  assign w_accept = bus.in_valid & (bus.in_first | (r_state == ACTIVE));
  assign w_end    = w_accept & bus.in_last;

  logic [DISP_BITS*MULT_R-1:0]   w_disp_all;
  logic [SUM_BITS_R-1:0]         w_sad_all;
  logic [MULT_R-1:0]             w_filt_all;

  genvar gi;
  generate
    for (gi = 0; gi < MULT_R; gi++) begin : g_row
      logic [SUM_BITS-1:0]  w_sad;
      logic [SUM_BITS-1:0]  r_best;
      logic [SUM_BITS-1:0]  r_second;
      logic [DISP_BITS-1:0] r_bdisp;
      logic [SUM_BITS-1:0]  w_best_next;
      logic [SUM_BITS-1:0]  w_second_next;
      logic [DISP_BITS-1:0] w_bdisp_next;
      logic [EXT_BITS-1:0]  w_prod;
      logic [EXT_BITS-1:0]  w_margin;
      logic [EXT_BITS-1:0]  w_thresh;
      logic                 w_filt;

      assign w_sad = bus.in_data[gi*SUM_BITS +: SUM_BITS];

      // Strict compares so a tie never displaces the earlier disparity.
      always_comb begin
        w_best_next   = r_best;
        w_second_next = r_second;
        w_bdisp_next  = r_bdisp;
        if (bus.in_first) begin
          w_best_next   = w_sad;
          w_second_next = '1;
          w_bdisp_next  = bus.in_disp;
        end else if (w_sad < r_best) begin
          w_second_next = r_best;
          w_best_next   = w_sad;
          w_bdisp_next  = bus.in_disp;
        end else if (w_sad < r_second) begin
          w_second_next = w_sad;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_best   <= '1;
          r_second <= '1;
          r_bdisp  <= '0;
        end else if (w_accept) begin
          r_best   <= w_best_next;
          r_second <= w_second_next;
          r_bdisp  <= w_bdisp_next;
        end
      end

      // Evaluated on the "next" values so the in_last beat takes part.
      assign w_prod   = EXT_BITS'(w_best_next) * UNIQ_EXT;
      assign w_margin = w_prod >> 4;
      assign w_thresh = EXT_BITS'(w_best_next) + w_margin;
      // With UNIQ_MUL=0 ties would still give best >= second, hence the explicit gate.
      assign w_filt   = (UNIQ_MUL != 0) && (w_thresh >= EXT_BITS'(w_second_next));

      assign w_disp_all[gi*DISP_BITS +: DISP_BITS] = w_bdisp_next;
      assign w_sad_all[gi*SUM_BITS +: SUM_BITS]    = w_best_next;
      assign w_filt_all[gi]                        = w_filt;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_out_valid    <= 1'b0;
      r_out_disp     <= '0;
      r_out_sad      <= '0;
      r_out_filtered <= '0;
    end else begin
      r_out_valid <= w_end;
      if (w_accept) begin
        r_state <= bus.in_last ? IDLE : ACTIVE;
      end
      if (w_end) begin
        r_out_disp     <= w_disp_all;
        r_out_sad      <= w_sad_all;
        r_out_filtered <= w_filt_all;
      end
    end
  end

  assign bus.out_valid    = r_out_valid;
  assign bus.out_disp     = r_out_disp;
  assign bus.out_sad      = r_out_sad;
  assign bus.out_filtered = r_out_filtered;

endmodule

// File: tb/tb_dlsc_stereobm_pipe_best.sv
module tb_dlsc_stereobm_pipe_best;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dlsc_stereobm_pipe_best_if #(.SUM_BITS(20), .MULT_R(3), .DISP_BITS(6)) bus4 ();
  dlsc_stereobm_pipe_best_if #(.SUM_BITS(20), .MULT_R(3), .DISP_BITS(6)) bus0 ();

  dlsc_stereobm_pipe_best #(.SUM_BITS(20), .MULT_R(3), .DISP_BITS(6), .UNIQ_MUL(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );
  dlsc_stereobm_pipe_best #(.SUM_BITS(20), .MULT_R(3), .DISP_BITS(6), .UNIQ_MUL(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  typedef struct {
    int          cyc;
    logic [17:0] disp;
    logic [59:0] sad;
    logic [2:0]  f4;
    logic [2:0]  f0;
  } exp_t;

  exp_t exp_q[$];

  // Call at the negedge where the in_last beat is set up; result is due one edge later.
  task automatic push_exp(input logic [5:0] d0, d1, d2, input logic [19:0] s0, s1, s2,
                          input logic [2:0] f4, f0);
    exp_t e;
    e.cyc  = cyc + 1;
    e.disp = {d2, d1, d0};
    e.sad  = {s2, s1, s0};
    e.f4   = f4;
    e.f0   = f0;
    exp_q.push_back(e);
  endtask

  task automatic beat(input logic v, f, l, input logic [5:0] d, input logic [19:0] s0, s1, s2);
    bus4.in_valid = v; bus4.in_first = f; bus4.in_last = l;
    bus4.in_disp = d;  bus4.in_data = {s2, s1, s0};
    bus0.in_valid = v; bus0.in_first = f; bus0.in_last = l;
    bus0.in_disp = d;  bus0.in_data = {s2, s1, s0};
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 6'd0, 20'd0, 20'd0, 20'd0);
  endtask

  // Scoreboard monitor: every out_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus4.out_valid !== bus0.out_valid) begin
      total++; bad++;
      $display("FAIL valid_pair: uniq4=%b uniq0=%b cyc=%0d", bus4.out_valid, bus0.out_valid, cyc);
    end
    if (bus4.out_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: got out_valid=1 expected none cyc=%0d", cyc);
      end else begin
        e = exp_q.pop_front();
        if (cyc !== e.cyc) begin
          bad++; $display("FAIL latency: got cyc=%0d expected cyc=%0d", cyc, e.cyc);
        end
        total++;
        if (bus4.out_disp !== e.disp || bus0.out_disp !== e.disp) begin
          bad++; $display("FAIL out_disp: got %h/%h expected %h", bus4.out_disp, bus0.out_disp, e.disp);
        end
        total++;
        if (bus4.out_sad !== e.sad || bus0.out_sad !== e.sad) begin
          bad++; $display("FAIL out_sad: got %h/%h expected %h", bus4.out_sad, bus0.out_sad, e.sad);
        end
        total++;
        if (bus4.out_filtered !== e.f4) begin
          bad++; $display("FAIL filtered_u4: got %b expected %b", bus4.out_filtered, e.f4);
        end
        total++;
        if (bus0.out_filtered !== e.f0) begin
          bad++; $display("FAIL filtered_u0: got %b expected %b", bus0.out_filtered, e.f0);
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    total++;
    if (bus4.out_valid !== 1'b0 || bus0.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b/%b expected 0", bus4.out_valid, bus0.out_valid);
    end
    total++;
    if (bus4.out_disp !== 18'd0 || bus0.out_disp !== 18'd0) begin
      bad++; $display("FAIL reset_disp: got %h/%h expected 0", bus4.out_disp, bus0.out_disp);
    end
    total++;
    if (bus4.out_sad !== 60'd0 || bus0.out_sad !== 60'd0) begin
      bad++; $display("FAIL reset_sad: got %h/%h expected 0", bus4.out_sad, bus0.out_sad);
    end
    total++;
    if (bus4.out_filtered !== 3'd0 || bus0.out_filtered !== 3'd0) begin
      bad++; $display("FAIL reset_filt: got %b/%b expected 0", bus4.out_filtered, bus0.out_filtered);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic;
    beat(1, 1, 0, 6'd0, 20'd100, 20'd60, 20'd500);
    beat(1, 0, 0, 6'd1, 20'd50,  20'd40, 20'd400);
    beat(1, 0, 0, 6'd2, 20'd80,  20'd42, 20'd300);
    push_exp(6'd1, 6'd1, 6'd3, 20'd50, 20'd40, 20'd200, 3'b010, 3'b000);
    beat(1, 0, 1, 6'd3, 20'd90,  20'd70, 20'd200);
    idle(4);
    total++;
    if (bus4.out_sad[19:0] !== 20'd50 || bus4.out_disp[5:0] !== 6'd1) begin
      bad++; $display("FAIL hold: got sad=%0d disp=%0d expected sad=50 disp=1",
                      bus4.out_sad[19:0], bus4.out_disp[5:0]);
    end
  endtask

  task automatic test_tie;
    beat(1, 1, 0, 6'd0, 20'd5, 20'd1000, 20'd30);
    beat(1, 0, 0, 6'd1, 20'd9, 20'd1000, 20'd30);
    push_exp(6'd2, 6'd2, 6'd0, 20'd3, 20'd999, 20'd30, 3'b110, 3'b000);
    beat(1, 0, 1, 6'd2, 20'd3, 20'd999,  20'd30);
    idle(2);
  endtask

  task automatic test_single_beat;
    push_exp(6'd5, 6'd5, 6'd5, 20'd7, 20'd0, 20'hFFFFF, 3'b100, 3'b000);
    beat(1, 1, 1, 6'd5, 20'd7, 20'd0, 20'hFFFFF);
    idle(2);
  endtask

  task automatic test_back_to_back;
    beat(1, 1, 0, 6'd0, 20'd10, 20'd20, 20'd5);
    push_exp(6'd0, 6'd1, 6'd0, 20'd10, 20'd10, 20'd5, 3'b100, 3'b000);
    beat(1, 0, 1, 6'd1, 20'd20, 20'd10, 20'd5);
    beat(1, 1, 0, 6'd7, 20'd100, 20'd300, 20'd1000);
    beat(1, 0, 0, 6'd8, 20'd90,  20'd400, 20'd999);
    beat(0, 0, 0, 6'd63, 20'd1, 20'd1, 20'd1);
    beat(0, 0, 1, 6'd63, 20'd1, 20'd1, 20'd1);
    beat(1, 0, 0, 6'd9, 20'd95,  20'd350, 20'd2000);
    beat(0, 1, 0, 6'd63, 20'd1, 20'd1, 20'd1);
    push_exp(6'd8, 6'd10, 6'd8, 20'd90, 20'd100, 20'd999, 3'b101, 3'b000);
    beat(1, 0, 1, 6'd10, 20'd200, 20'd100, 20'd1001);
    idle(2);
  endtask

  task automatic test_restart;
    beat(1, 0, 0, 6'd3, 20'd1, 20'd1, 20'd1);
    beat(1, 0, 1, 6'd4, 20'd1, 20'd1, 20'd1);
    idle(1);
    beat(1, 1, 0, 6'd0, 20'd2, 20'd2, 20'd2);
    beat(1, 0, 0, 6'd1, 20'd3, 20'd3, 20'd3);
    beat(1, 1, 0, 6'd20, 20'd50, 20'd60, 20'd70);
    beat(1, 0, 0, 6'd21, 20'd40, 20'd80, 20'd200);
    push_exp(6'd21, 6'd22, 6'd20, 20'd40, 20'd55, 20'd70, 3'b011, 3'b000);
    beat(1, 0, 1, 6'd22, 20'd45, 20'd55, 20'd300);
    idle(2);
  endtask

  task automatic test_reset_midrun;
    beat(1, 1, 0, 6'd0, 20'd2, 20'd2, 20'd2);
    beat(1, 0, 0, 6'd1, 20'd1, 20'd1, 20'd1);
    rst = 1'b1;
    idle(1);
    total++;
    if (bus4.out_valid !== 1'b0 || bus4.out_disp !== 18'd0 || bus4.out_sad !== 60'd0 ||
        bus4.out_filtered !== 3'd0) begin
      bad++; $display("FAIL midrun_reset: got v=%b disp=%h sad=%h filt=%b expected all 0",
                      bus4.out_valid, bus4.out_disp, bus4.out_sad, bus4.out_filtered);
    end
    rst = 1'b0;
    beat(1, 0, 1, 6'd2, 20'd1, 20'd1, 20'd1);
    beat(1, 1, 0, 6'd0, 20'd9, 20'd1, 20'd4);
    beat(1, 0, 0, 6'd1, 20'd8, 20'd2, 20'd4);
    beat(1, 0, 0, 6'd2, 20'd7, 20'd3, 20'd1);
    push_exp(6'd3, 6'd0, 6'd2, 20'd6, 20'd1, 20'd1, 3'b001, 3'b000);
    beat(1, 0, 1, 6'd3, 20'd6, 20'd4, 20'd4);
    idle(3);
  endtask

  initial begin
    bus4.in_valid = 0; bus4.in_first = 0; bus4.in_last = 0; bus4.in_disp = 0; bus4.in_data = 0;
    bus0.in_valid = 0; bus0.in_first = 0; bus0.in_last = 0; bus0.in_disp = 0; bus0.in_data = 0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_tie;
    test_single_beat;
    test_back_to_back;
    test_restart;
    test_reset_midrun;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL missing_results: got %0d undelivered expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
